// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the ID-stage hazard scoreboard:
// stall-cause codes and producer latencies.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_LOAD_USE   = 2'b01,
        CAUSE_BRANCH_DEP = 2'b10,
        CAUSE_LINK_DEP   = 2'b11
    } cause_e;

    localparam logic [1:0] LAT_ALU  = 2'd1;
    localparam logic [1:0] LAT_LOAD = 2'd2;
    localparam logic [1:0] LAT_LINK = 2'd2;

    localparam logic [4:0] REG_LINK = 5'd31;

    // r31 is never forwarded, so it always waits for WB
    function automatic logic [1:0] lat_of(
        input logic [4:0] rd,
        input logic       is_load
    );
        if (rd == REG_LINK)
            return LAT_LINK;
        else if (is_load)
            return LAT_LOAD;
        else
            return LAT_ALU;
    endfunction

    // Returns {hazard, cause} for one source operand
    function automatic logic [2:0] src_haz(
        input logic [4:0] s,
        input logic       en,
        input logic [1:0] p,
        input logic       br
    );
        logic [2:0] res;
        res = {1'b0, CAUSE_NONE};
        if (en && s != 5'd0) begin
            if (s == REG_LINK)
                res = {p != 2'd0, CAUSE_LINK_DEP};
            else if (br)
                res = {p != 2'd0, CAUSE_BRANCH_DEP};
            else
                res = {p == 2'd2, CAUSE_LOAD_USE};
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_cnt.sv
// One 2-bit pending-write countdown cell.
// A load overrides the free-running decrement.
module sb_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld,
    input  logic [1:0] i_ld_val,
    output logic [1:0] o_q
);

    logic [1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= 2'd0;
        else if (i_ld)
            r_q <= i_ld_val;
        else if (r_q != 2'd0)
            r_q <= r_q - 2'd1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage producer scoreboard: stalls consumers that
// no forwarding path or the register file can serve yet.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic [4:0]       id_rd,
    input  logic             id_RFWr,
    input  logic             id_DMRd,
    input  logic             flush_id,
    output logic             stall,
    output logic             bubble,
    output logic             issue,
    output logic [1:0]       stall_cause,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [1:0] w_pend [32];
    logic       w_live;
    logic       w_wr;
    logic [1:0] w_lat;
    logic [2:0] w_hz_rs;
    logic [2:0] w_hz_rt;
    logic       w_stall;
    logic [1:0] w_c_rs;
    logic [1:0] w_c_rt;

    logic [CNT_W-1:0] r_stall_cycles;

    assign w_pend[0] = 2'd0;
    assign w_live    = id_valid & ~flush_id;
    assign w_wr      = issue & id_RFWr & (id_rd != 5'd0);
    assign w_lat     = lat_of(id_rd, id_DMRd);

    for (genvar g = 1; g < 32; g++) begin : g_cnt
        sb_cnt u_cnt (
            .clk      (clk),
            .rst      (rst),
            .i_ld     (w_wr && id_rd == 5'(g)),
            .i_ld_val (w_lat),
            .o_q      (w_pend[g])
        );
    end

    assign w_hz_rs = src_haz(id_rs, id_use_rs,
                             w_pend[id_rs], id_is_branch);
    assign w_hz_rt = src_haz(id_rt, id_use_rt,
                             w_pend[id_rt], id_is_branch);

    assign w_stall = w_live & (w_hz_rs[2] | w_hz_rt[2]);
    assign stall   = w_stall;
    assign bubble  = w_stall;
    assign issue   = w_live & ~w_stall;

    // Codes are ordered by priority, so the larger one wins
    assign w_c_rs = w_hz_rs[2] ? w_hz_rs[1:0] : 2'b00;
    assign w_c_rt = w_hz_rt[2] ? w_hz_rt[1:0] : 2'b00;

    always_comb begin
        stall_cause = CAUSE_NONE;
        if (w_stall)
            stall_cause = (w_c_rs > w_c_rt) ? w_c_rs : w_c_rt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_stall && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance
// with a 4-bit counter covers saturation.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_is_branch;
    logic [4:0]  id_rd;
    logic        id_RFWr;
    logic        id_DMRd;
    logic        flush_id;
    logic        stall;
    logic        bubble;
    logic        issue;
    logic [1:0]  stall_cause;
    logic [15:0] stall_cycles;
    logic        s_stall;
    logic        s_bubble;
    logic        s_issue;
    logic [1:0]  s_cause;
    logic [3:0]  s_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_rd        (id_rd),
        .id_RFWr      (id_RFWr),
        .id_DMRd      (id_DMRd),
        .flush_id     (flush_id),
        .stall        (stall),
        .bubble       (bubble),
        .issue        (issue),
        .stall_cause  (stall_cause),
        .stall_cycles (stall_cycles)
    );

    hazard_scoreboard #(.CNT_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_rd        (id_rd),
        .id_RFWr      (id_RFWr),
        .id_DMRd      (id_DMRd),
        .flush_id     (flush_id),
        .stall        (s_stall),
        .bubble       (s_bubble),
        .issue        (s_issue),
        .stall_cause  (s_cause),
        .stall_cycles (s_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v rs rt urs urt br rd wr ld fl
    task automatic drv(
        input logic       v,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       urs,
        input logic       urt,
        input logic       br,
        input logic [4:0] rd,
        input logic       wr,
        input logic       ld,
        input logic       fl
    );
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_is_branch = br;
        id_rd        = rd;
        id_RFWr      = wr;
        id_DMRd      = ld;
        flush_id     = fl;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL rst_cnt_hold got=%0d want=0",
                     stall_cycles);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            bad++;
            $display("FAIL rst_stall got=%b/%b want=0/0",
                     stall, bubble);
        end
        total++;
        if (issue !== 1'b1) begin
            bad++;
            $display("FAIL rst_issue got=%b want=1", issue);
        end
        total++;
        if (stall_cause !== 2'b00) begin
            bad++;
            $display("FAIL rst_cause got=%b want=00",
                     stall_cause);
        end
        total++;
        if (stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL rst_cnt got=%0d want=0",
                     stall_cycles);
        end
        // r31 branch reader stalls on any nonzero pend
        drv(1, 31, 0, 1, 0, 1, 0, 0, 0, 0);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_pend31 got=%b want=0", stall);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 1, 0);
        total++;
        if (issue !== 1'b1) begin
            bad++;
            $display("FAIL lu_lw_issue got=%b want=1", issue);
        end
        tick();
        drv(1, 8, 8, 1, 1, 0, 9, 1, 0, 0);
        total++;
        if (stall !== 1'b1 || bubble !== 1'b1
            || issue !== 1'b0) begin
            bad++;
            $display("FAIL lu_stall got=%b%b%b want=110",
                     stall, bubble, issue);
        end
        total++;
        if (stall_cause !== 2'b01) begin
            bad++;
            $display("FAIL lu_cause got=%b want=01",
                     stall_cause);
        end
        tick();
        total++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            bad++;
            $display("FAIL lu_release got=%b%b want=01",
                     stall, issue);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 16'd1) begin
            bad++;
            $display("FAIL lu_cnt got=%0d want=1",
                     stall_cycles);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 4, 1, 1, 0);
        tick();
        drv(1, 4, 0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (stall !== 1'b1 || stall_cause !== 2'b10) begin
                bad++;
                $display("FAIL br_ld_stall%0d got=%b/%b want=1/10",
                         i, stall, stall_cause);
            end
            tick();
        end
        total++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            bad++;
            $display("FAIL br_ld_issue got=%b%b want=10",
                     issue, stall);
        end
        tick();
        drv(1, 1, 2, 1, 1, 0, 4, 1, 0, 0);
        tick();
        drv(1, 4, 0, 1, 1, 1, 0, 0, 0, 0);
        total++;
        if (stall !== 1'b1 || stall_cause !== 2'b10) begin
            bad++;
            $display("FAIL br_alu_stall got=%b/%b want=1/10",
                     stall, stall_cause);
        end
        tick();
        total++;
        if (issue !== 1'b1) begin
            bad++;
            $display("FAIL br_alu_issue got=%b want=1", issue);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 16'd3) begin
            bad++;
            $display("FAIL br_cnt got=%0d want=3",
                     stall_cycles);
        end
    endtask

    task automatic test_link_zero();
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 31, 1, 0, 0);
        tick();
        drv(1, 31, 0, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (stall !== 1'b1 || stall_cause !== 2'b11) begin
                bad++;
                $display("FAIL link_stall%0d got=%b/%b want=1/11",
                         i, stall, stall_cause);
            end
            tick();
        end
        total++;
        if (issue !== 1'b1) begin
            bad++;
            $display("FAIL link_issue got=%b want=1", issue);
        end
        // load into r0 must never be tracked
        drv(1, 1, 2, 1, 1, 0, 0, 1, 1, 0);
        tick();
        drv(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        total++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            bad++;
            $display("FAIL zero_reg got=%b%b want=01",
                     stall, issue);
        end
    endtask

    task automatic test_flush_waw();
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 1, 0);
        tick();
        drv(1, 8, 0, 1, 0, 0, 8, 1, 1, 1);
        total++;
        if (stall !== 1'b0 || issue !== 1'b0
            || bubble !== 1'b0) begin
            bad++;
            $display("FAIL flush_ctl got=%b%b%b want=000",
                     stall, issue, bubble);
        end
        tick();
        drv(1, 8, 0, 1, 0, 0, 9, 1, 0, 0);
        total++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            bad++;
            $display("FAIL flush_nowrite got=%b%b want=01",
                     stall, issue);
        end
        tick();
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 1, 0);
        tick();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 0, 0);
        tick();
        drv(1, 8, 8, 1, 1, 0, 9, 1, 0, 0);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL waw_alu got=%b want=0", stall);
        end
        tick();
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 0, 0);
        tick();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 1, 0);
        tick();
        drv(1, 8, 0, 1, 0, 0, 9, 1, 0, 0);
        total++;
        if (stall !== 1'b1 || stall_cause !== 2'b01) begin
            bad++;
            $display("FAIL waw_load got=%b/%b want=1/01",
                     stall, stall_cause);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 8, 1, 1, 0);
        tick();
        drv(1, 8, 0, 1, 0, 0, 9, 1, 0, 0);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL mr_pre got=%b want=1", stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            bad++;
            $display("FAIL mr_drop got=%b%b want=01",
                     stall, issue);
        end
        total++;
        if (stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL mr_cnt got=%0d want=0",
                     stall_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int r = 0; r < 10; r++) begin
            drv(1, 0, 0, 0, 0, 0, 31, 1, 0, 0);
            tick();
            drv(1, 31, 0, 1, 0, 1, 0, 0, 0, 0);
            tick();
            tick();
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (s_cycles !== 4'd15) begin
            bad++;
            $display("FAIL sat_hold got=%0d want=15", s_cycles);
        end
        total++;
        if (stall_cycles !== 16'd20) begin
            bad++;
            $display("FAIL sat_wide got=%0d want=20",
                     stall_cycles);
        end
        tick();
        total++;
        if (s_cycles !== 4'd15) begin
            bad++;
            $display("FAIL sat_keep got=%0d want=15", s_cycles);
        end
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_branch();
        test_link_zero();
        test_flush_waw();
        test_mid_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
